// File: rtl/hdlc_rx_framer.sv
// Bit-serial HDLC receive framer: flag hunt, zero destuffing, LSB-first byte
// assembly and frame delimiting with abort/misalignment/overflow handling.
module hdlc_rx_framer #(
  parameter int MAX_BYTES = 64,
  parameter int LEN_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  output logic [7:0]       byte_data_o,
  output logic             byte_valid_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             frame_abort_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic             in_frame_o
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);

  typedef enum logic [1:0] {HUNT, SYNC, FRAME} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ones_q, ones_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       data_q, data_d;
  logic             bv_q, bv_d, fs_q, fs_d, fe_q, fe_d, fa_q, fa_d;
  logic             is_shift, is_flag, is_abort, byte_done;

  // Line bit classification from the run of consecutive ones.
  always_comb begin
    is_shift = 1'b0;
    is_flag  = 1'b0;
    is_abort = 1'b0;
    ones_d   = ones_q;
    if (in_valid_i) begin
      if (in_bit_i) begin
        if (ones_q <= 3'd5) begin
          ones_d   = ones_q + 3'd1;
          is_shift = 1'b1;
        end else if (ones_q == 3'd6) begin
          ones_d   = 3'd7;
          is_abort = 1'b1;
        end
      end else begin
        ones_d = 3'd0;
        if (ones_q <= 3'd4)      is_shift = 1'b1;
        else if (ones_q == 3'd6) is_flag  = 1'b1;
      end
    end
  end

  assign byte_done = is_shift && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    data_d     = data_q;
    len_d      = len_q;
    bv_d       = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    fa_d       = 1'b0;
    if (is_shift) begin
      sh_d      = {in_bit_i, sh_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (is_flag) bit_cnt_d = 3'd0;
    case (state_q)
      HUNT: if (is_flag) state_d = SYNC;
      SYNC: begin
        if (byte_done) begin
          data_d     = sh_d;
          bv_d       = 1'b1;
          fs_d       = 1'b1;
          byte_cnt_d = LEN_W'(1);
          state_d    = FRAME;
        end else if (is_abort) begin
          state_d = HUNT;
        end
      end
      FRAME: begin
        if (byte_done) begin
          if (byte_cnt_q == MAX_L) begin
            fa_d       = 1'b1;
            byte_cnt_d = '0;
            state_d    = HUNT;
          end else begin
            data_d     = sh_d;
            bv_d       = 1'b1;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (is_flag) begin
          // Aligned only if the flag's leading 0111111 filled exactly 7 bits.
          if (bit_cnt_q == 3'd7) begin
            fe_d  = 1'b1;
            len_d = byte_cnt_q;
          end else begin
            fa_d = 1'b1;
          end
          byte_cnt_d = '0;
          state_d    = SYNC;
        end else if (is_abort) begin
          fa_d       = 1'b1;
          byte_cnt_d = '0;
          state_d    = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      ones_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      sh_q       <= '0;
      data_q     <= '0;
      bv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      fa_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      bv_q       <= bv_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      fa_q       <= fa_d;
    end
  end

  assign byte_data_o   = data_q;
  assign byte_valid_o  = bv_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign frame_abort_o = fa_q;
  assign frame_len_o   = len_q;
  assign in_frame_o    = (state_q == FRAME);

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Scoreboard bench for hdlc_rx_framer: directed bit streams push expected
// events; a negedge monitor pops and compares each output pulse.
module tb_hdlc_rx_framer;

  logic clk = 1'b0;
  logic rst, vld, bt, vld2, bt2;
  logic [7:0] bd, bd2;
  logic bv, fs, fe, fa, inf, bv2, fs2, fe2, fa2, inf2;
  logic [6:0] fl, fl2;

  always #5 clk = ~clk;

  hdlc_rx_framer #(.MAX_BYTES(64), .LEN_W(7)) dut (
    .clk(clk), .reset(rst), .in_valid_i(vld), .in_bit_i(bt),
    .byte_data_o(bd), .byte_valid_o(bv), .frame_start_o(fs), .frame_end_o(fe),
    .frame_abort_o(fa), .frame_len_o(fl), .in_frame_o(inf));

  hdlc_rx_framer #(.MAX_BYTES(2), .LEN_W(7)) dut2 (
    .clk(clk), .reset(rst), .in_valid_i(vld2), .in_bit_i(bt2),
    .byte_data_o(bd2), .byte_valid_o(bv2), .frame_start_o(fs2), .frame_end_o(fe2),
    .frame_abort_o(fa2), .frame_len_o(fl2), .in_frame_o(inf2));

  // Event word: {kind[1:0], start, len[6:0], data[7:0]}; kind 0=byte 1=end 2=abort
  logic [17:0] q1[$];
  logic [17:0] q2[$];
  int nvec = 0;
  int nerr = 0;
  int gap  = 0;
  bit sel  = 1'b0;

  function automatic logic [17:0] ev_byte(input logic [7:0] d, input logic s);
    return {2'd0, s, 7'd0, d};
  endfunction
  function automatic logic [17:0] ev_end(input logic [6:0] l);
    return {2'd1, 1'b0, l, 8'd0};
  endfunction
  function automatic logic [17:0] ev_abort();
    return {2'd2, 16'd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic s, input logic e,
                     input logic a, input logic [7:0] d, input logic [6:0] l);
    logic [17:0] got, exp;
    int npulse;
    npulse = int'(v) + int'(e) + int'(a);
    if (s && !v) begin
      nvec++; nerr++;
      $display("FAIL dut%0d frame_start without byte_valid", w);
    end
    if (npulse != 0) begin
      nvec++;
      got = v ? {2'd0, s, 7'd0, d} : (e ? {2'd1, 1'b0, l, 8'd0} : {2'd2, 16'd0});
      if ((w == 1) ? (q1.size() == 0) : (q2.size() == 0)) begin
        nerr++;
        $display("FAIL dut%0d unexpected event: got %h expected none", w, got);
      end else begin
        exp = (w == 1) ? q1.pop_front() : q2.pop_front();
        if (got !== exp || npulse > 1) begin
          nerr++;
          $display("FAIL dut%0d event: got %h (pulses %0d) expected %h", w, got, npulse, exp);
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mon(1, bv, fs, fe, fa, bd, fl);
      mon(2, bv2, fs2, fe2, fa2, bd2, fl2);
    end
  end

  task automatic sb(input logic b);
    @(negedge clk);
    if (sel) begin vld2 = 1'b1; bt2 = b; end
    else     begin vld  = 1'b1; bt  = b; end
    if (gap > 0) begin
      @(negedge clk);
      vld = 1'b0; vld2 = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    vld = 1'b0; vld2 = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic sbyte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) sb(v[i]);
  endtask

  task automatic flag();
    sbyte(8'h7E);
  endtask

  task automatic test1();
    q1.push_back(ev_byte(8'hA5, 1'b1));
    flag(); sbyte(8'hA5); idle(2);
    chk("t1 in_frame mid", 32'(inf), 32'd1);
    q1.push_back(ev_end(7'd1));
    flag(); idle(3);
    chk("t1 in_frame after", 32'(inf), 32'd0);
    chk("t1 frame_len held", 32'(fl), 32'd1);
  endtask

  task automatic test2();
    logic [8:0] stuffed;
    stuffed = 9'b111_0_11111;  // LSB first: 1,1,1,1,1,0,1,1,1
    flag(); flag(); flag(); idle(3);
    chk("t2 idle flags no output", 32'(q1.size()), 32'd0);
    q1.push_back(ev_byte(8'hFF, 1'b1));
    q1.push_back(ev_end(7'd1));
    flag();
    for (int i = 0; i < 9; i++) sb(stuffed[i]);
    flag(); idle(3);
  endtask

  task automatic test4();
    q1.push_back(ev_byte(8'h55, 1'b1));
    q1.push_back(ev_byte(8'hF2, 1'b0));  // flag bits wrap the misaligned byte
    q1.push_back(ev_abort());
    flag(); sbyte(8'h55); sb(1'b0); sb(1'b1); sb(1'b0); flag(); idle(3);
    chk("t4 in_frame after misalign", 32'(inf), 32'd0);
    q1.push_back(ev_byte(8'h66, 1'b1));
    q1.push_back(ev_end(7'd1));
    sbyte(8'h66); flag(); idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vld = 1'b0; bt = 1'b0; vld2 = 1'b0; bt2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset byte_data", 32'(bd), 32'd0);
    chk("reset pulses", {28'd0, bv, fs, fe, fa}, 32'd0);
    chk("reset frame_len", 32'(fl), 32'd0);
    chk("reset in_frame", 32'(inf), 32'd0);
    rst = 1'b0;
    idle(2);

    test1();
    test2();

    // abort then hunt
    q1.push_back(ev_byte(8'h12, 1'b1));
    q1.push_back(ev_abort());
    flag(); sbyte(8'h12);
    for (int i = 0; i < 8; i++) sb(1'b1);
    idle(3);
    chk("t3 in_frame after abort", 32'(inf), 32'd0);
    sbyte(8'h34); idle(3);
    chk("t3 hunt no output", 32'(q1.size()), 32'd0);
    q1.push_back(ev_byte(8'h56, 1'b1));
    q1.push_back(ev_end(7'd1));
    flag(); sbyte(8'h56); flag(); idle(3);

    test4();

    // overflow on the MAX_BYTES=2 instance
    sel = 1'b1;
    q2.push_back(ev_byte(8'h01, 1'b1));
    q2.push_back(ev_byte(8'h02, 1'b0));
    q2.push_back(ev_abort());
    flag(); sbyte(8'h01); sbyte(8'h02); sbyte(8'h03); idle(3);
    chk("t5 in_frame after overflow", 32'(inf2), 32'd0);
    sel = 1'b0;

    // reset mid-frame
    q1.push_back(ev_byte(8'h77, 1'b1));
    flag(); sbyte(8'h77); idle(2);
    chk("t6 in_frame before reset", 32'(inf), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6 reset byte_data", 32'(bd), 32'd0);
    chk("t6 reset frame_len", 32'(fl), 32'd0);
    chk("t6 reset pulses", {28'd0, bv, fs, fe, fa}, 32'd0);
    chk("t6 reset in_frame", 32'(inf), 32'd0);
    sbyte(8'h55); idle(3);
    chk("t6 hunt after reset", 32'(q1.size()), 32'd0);
    q1.push_back(ev_byte(8'h66, 1'b1));
    q1.push_back(ev_end(7'd1));
    flag(); sbyte(8'h66); flag(); idle(3);

    // same sequences with 3-cycle in_valid gaps
    gap = 3;
    test1();
    test2();
    test4();
    gap = 0;

    idle(5);
    chk("dut1 expected events drained", 32'(q1.size()), 32'd0);
    chk("dut2 expected events drained", 32'(q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
